// File: rtl/snake_pkg.sv
// Shared playfield constants and food-spawner state encoding.
// FOOD_SCAN_FALLBACK_EN adds the SCAN state used by the exhaustive fallback search.
package snake_pkg;

    localparam int unsigned GRID_W    = 20;
    localparam int unsigned GRID_H    = 15;
    localparam int unsigned CELLS     = GRID_W * GRID_H;
    localparam int unsigned X_W       = 5;
    localparam int unsigned Y_W       = 4;
    localparam int unsigned IDX_W     = 9;
    localparam int unsigned MAX_TRIES = 64;
    localparam int unsigned TRY_W     = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_DIV,
`ifdef FOOD_SCAN_FALLBACK_EN
        ST_QUERY,
        ST_SCAN
`else
        ST_QUERY
`endif
    } state_t;

endpackage

// File: rtl/food_spawner_if.sv
// Food spawner bus: random input, spawn request, occupancy query/answer and food result.
interface food_spawner_if;

    logic [snake_pkg::IDX_W-1:0] rand_num;
    logic                        spawn_req;
    logic                        occ_query_valid;
    logic [snake_pkg::X_W-1:0]   occ_x;
    logic [snake_pkg::Y_W-1:0]   occ_y;
    logic                        occ_resp_valid;
    logic                        occ_hit;
    logic [snake_pkg::X_W-1:0]   food_x;
    logic [snake_pkg::Y_W-1:0]   food_y;
    logic                        food_valid;
    logic                        busy;
    logic                        spawn_fail;

    // Spawner side
    modport master (
        input  rand_num, spawn_req, occ_resp_valid, occ_hit,
        output occ_query_valid, occ_x, occ_y, food_x, food_y, food_valid, busy, spawn_fail
    );

    // Game-control / occupancy side
    modport slave (
        output rand_num, spawn_req, occ_resp_valid, occ_hit,
        input  occ_query_valid, occ_x, occ_y, food_x, food_y, food_valid, busy, spawn_fail
    );

endinterface

// File: rtl/food_cell_div.sv
// Iterative subtract divider: cell index -> (x, y), one row subtracted per step cycle.
module food_cell_div
    import snake_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [IDX_W-1:0] idx,
    output logic             done_c,
    output logic [X_W-1:0]   x_c,
    output logic [Y_W-1:0]   y_c
);

    logic [IDX_W-1:0] rem;
    logic [Y_W-1:0]   row;
    logic             fits_c;

    assign fits_c = rem < IDX_W'(GRID_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            row <= '0;
        end else if (start) begin
            rem <= idx;
            row <= '0;
        end else if (step && !fits_c) begin
            rem <= rem - IDX_W'(GRID_W);
            row <= row + Y_W'(1);
        end
    end

    assign done_c = step && fits_c;
    assign x_c    = X_W'(rem);
    assign y_c    = row;

endmodule

// File: rtl/food_spawner.sv
// Turns LFSR samples into a free food cell, retrying on out-of-range or occupied cells.
// FOOD_SCAN_FALLBACK_EN: when the try budget runs out, scan every cell row-major before failing.
module food_spawner
    import snake_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    food_spawner_if.master bus
);

`ifdef FOOD_SCAN_FALLBACK_EN
    localparam state_t ST_EXHAUST = ST_SCAN;
`else
    localparam state_t ST_EXHAUST = ST_IDLE;
`endif

    state_t           state, state_n;
    logic [TRY_W-1:0] tries, tries_n, tries_inc;

    logic             qv_q, qv_n;
    logic [X_W-1:0]   ox_q, ox_n, fx_q, fx_n;
    logic [Y_W-1:0]   oy_q, oy_n, fy_q, fy_n;
    logic             fv_q, fv_n;
    logic             fail_q, fail_n;
    logic             busy_q;

    logic             sample_ok_c, exhaust_c;
    logic             div_start, div_step, div_done_c;
    logic [X_W-1:0]   div_x_c;
    logic [Y_W-1:0]   div_y_c;

    assign sample_ok_c = bus.rand_num < IDX_W'(CELLS);
    assign tries_inc   = tries + TRY_W'(1);
    assign div_start   = (state == ST_SAMPLE) && sample_ok_c;
    assign div_step    = (state == ST_DIV);

    // Budget runs out on the last rejected sample or on a hit after the last accepted one
    assign exhaust_c = ((state == ST_SAMPLE) && !sample_ok_c && (tries_inc == TRY_W'(MAX_TRIES)))
                    || ((state == ST_QUERY) && bus.occ_resp_valid && bus.occ_hit
                        && (tries == TRY_W'(MAX_TRIES)));

`ifdef FOOD_SCAN_FALLBACK_EN
    logic last_cell_c;
    assign last_cell_c = (ox_q == X_W'(GRID_W - 1)) && (oy_q == Y_W'(GRID_H - 1));
`endif

    food_cell_div u_div (
        .clk    (clk),
        .rst    (rst),
        .start  (div_start),
        .step   (div_step),
        .idx    (bus.rand_num),
        .done_c (div_done_c),
        .x_c    (div_x_c),
        .y_c    (div_y_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (bus.spawn_req) state_n = ST_SAMPLE;
            ST_SAMPLE: begin
                if (sample_ok_c)    state_n = ST_DIV;
                else if (exhaust_c) state_n = ST_EXHAUST;
            end
            ST_DIV:    if (div_done_c) state_n = ST_QUERY;
            ST_QUERY: begin
                if (bus.occ_resp_valid) begin
                    if (!bus.occ_hit)   state_n = ST_IDLE;
                    else if (exhaust_c) state_n = ST_EXHAUST;
                    else                state_n = ST_SAMPLE;
                end
            end
`ifdef FOOD_SCAN_FALLBACK_EN
            ST_SCAN: begin
                if (bus.occ_resp_valid && (!bus.occ_hit || last_cell_c)) state_n = ST_IDLE;
            end
`endif
            default:   state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        tries_n = tries;
        qv_n    = qv_q;
        ox_n    = ox_q;
        oy_n    = oy_q;
        fx_n    = fx_q;
        fy_n    = fy_q;
        fv_n    = fv_q;
        fail_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.spawn_req) begin
                    fv_n    = 1'b0;
                    tries_n = '0;
                end
            end
            ST_SAMPLE: tries_n = tries_inc;
            ST_DIV: begin
                if (div_done_c) begin
                    ox_n = div_x_c;
                    oy_n = div_y_c;
                    qv_n = 1'b1;
                end
            end
            ST_QUERY: begin
                if (bus.occ_resp_valid) begin
                    qv_n = 1'b0;
                    if (!bus.occ_hit) begin
                        fx_n = ox_q;
                        fy_n = oy_q;
                        fv_n = 1'b1;
                    end
                end
            end
`ifdef FOOD_SCAN_FALLBACK_EN
            ST_SCAN: begin
                if (bus.occ_resp_valid) begin
                    if (!bus.occ_hit) begin
                        qv_n = 1'b0;
                        fx_n = ox_q;
                        fy_n = oy_q;
                        fv_n = 1'b1;
                    end else if (last_cell_c) begin
                        qv_n   = 1'b0;
                        fail_n = 1'b1;
                    end else if (ox_q == X_W'(GRID_W - 1)) begin
                        ox_n = '0;
                        oy_n = oy_q + Y_W'(1);
                    end else begin
                        ox_n = ox_q + X_W'(1);
                    end
                end
            end
`endif
            default: ;
        endcase
        if (exhaust_c) begin
`ifdef FOOD_SCAN_FALLBACK_EN
            qv_n = 1'b1;
            ox_n = '0;
            oy_n = '0;
`else
            fail_n = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tries  <= '0;
            qv_q   <= 1'b0;
            ox_q   <= '0;
            oy_q   <= '0;
            fx_q   <= '0;
            fy_q   <= '0;
            fv_q   <= 1'b0;
            fail_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            tries  <= tries_n;
            qv_q   <= qv_n;
            ox_q   <= ox_n;
            oy_q   <= oy_n;
            fx_q   <= fx_n;
            fy_q   <= fy_n;
            fv_q   <= fv_n;
            fail_q <= fail_n;
            busy_q <= (state_n != ST_IDLE);
        end
    end

    assign bus.occ_query_valid = qv_q;
    assign bus.occ_x           = ox_q;
    assign bus.occ_y           = oy_q;
    assign bus.food_x          = fx_q;
    assign bus.food_y          = fy_q;
    assign bus.food_valid      = fv_q;
    assign bus.spawn_fail      = fail_q;
    assign bus.busy            = busy_q;

endmodule

// File: doc/food_spawner.md
# food_spawner

Consumes the free-running 9-bit pseudo-random stream from the game's LFSR generator and turns it into a legal food position on the playfield grid. On request it samples the random value, rejects out-of-range samples, converts the cell index to x/y, asks the snake-body occupancy logic whether the cell is taken, and retries until a free cell is found or the try budget runs out. It sits between the random generator and the game-control FSM.

## Interface
- GRID_W, 20, playfield width in cells
- GRID_H, 15, playfield height in cells (GRID_W*GRID_H ≤ 512)
- MAX_TRIES, 64, random samples allowed per spawn before fallback/fail
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- rand_num  in  9  LFSR output, new value every cycle
- spawn_req  in  1  single-cycle request for a new food position
- occ_query_valid  out  1  occupancy query outstanding
- occ_x  out  5  queried column
- occ_y  out  4  queried row
- occ_resp_valid  in  1  occupancy answer valid (same cycle as query allowed)
- occ_hit  in  1  1 = queried cell holds snake body
- food_x  out  5  current food column
- food_y  out  4  current food row
- food_valid  out  1  food_x/food_y hold a placed food
- busy  out  1  spawn in progress
- spawn_fail  out  1  one-cycle pulse: no free cell found

## Operation
- States: IDLE, SAMPLE, DIV, QUERY, SCAN (macro only).
- IDLE: spawn_req=1 → clear food_valid, clear try counter, go SAMPLE. spawn_req in any other state ignored.
- SAMPLE: capture rand_num as idx, try counter +1. idx ≥ GRID_W*GRID_H → stay SAMPLE (next LFSR value); else rem=idx, row=0, go DIV. Try counter reaching MAX_TRIES on a rejected sample → budget exhausted.
- DIV: rem ≥ GRID_W → rem −= GRID_W, row +1; else occ_x=rem, occ_y=row, go QUERY. No divider/multiplier operators.
- QUERY: occ_query_valid=1, occ_x/occ_y stable until occ_resp_valid. Miss → food_x/food_y load, food_valid=1, go IDLE. Hit → SAMPLE if budget remains, else exhausted.
- Exhausted: without macro, spawn_fail pulse, go IDLE, food_valid stays 0.
- occ_resp_valid outside QUERY/SCAN ignored.
- busy = (state ≠ IDLE).
- Reset mid-operation: all state abandoned, outputs to reset values next cycle.

## Timing
- Reset values: occ_query_valid 0, occ_x/occ_y 0, food_x/food_y 0, food_valid 0, busy 0, spawn_fail 0, state IDLE.
- spawn_req sampled at cycle 0; SAMPLE cycle 1; DIV cycles 2..2+row; QUERY first at cycle 3+row.
- Same-cycle miss response: food_valid high from cycle 4+row; busy low same cycle.
- food_valid falls cycle 1 after accepted spawn_req.
- spawn_fail asserted exactly one cycle, coincident with busy falling.
- Each rejected or hit sample costs ≥1 extra cycle; no combinational path rand_num → any output.

## Configuration
- FOOD_SCAN_FALLBACK_EN defined: on budget exhaustion enter SCAN, query cells row-major from (0,0), x wraps at GRID_W−1 with row +1; first miss places food; spawn_fail only after cell (GRID_W−1, GRID_H−1) hits.
- Undefined: no SCAN state; exhaustion → immediate spawn_fail.

## Structure
- Shared package snake_pkg: GRID_W, GRID_H, CELLS, coordinate widths (X_W=5, Y_W=4), state enum.
- One natural sub-module: food_cell_div (iterative subtract divider, idx → x/y, start/done).

## Test plan
- rand_num=45 at cycle 1, occ_hit=0 same-cycle → food_x=5, food_y=2, food_valid high at cycle 6.
- rand_num=400, 310, then 21 → two rejections, final food (1,1), try count 3.
- First query occ_hit=1, second sample 0 miss → food (0,0); occ_x/occ_y held stable while occ_resp_valid delayed 3 cycles.
- occ_hit=1 forever, macro off → spawn_fail pulse after 64 samples, food_valid 0; macro on → full scan of 300 cells then spawn_fail.
- rst asserted during DIV → next cycle busy 0, occ_query_valid 0, food_valid 0; later spawn_req works normally.
- spawn_req pulsed while busy → ignored, spawn completes once.
